// File: rtl/i2s_frame_serializer.sv
// I2S transmitter for the NCO sample path: paces the NCO with a per-frame strobe,
// latches one sample per frame and sends it on both slots (mono duplicated).
//
// state | meaning
// IDLE  | bclk/lrclk/sd held low, waiting for enable
// RUN   | BCLK running, frames shifted out back-to-back
module i2s_frame_serializer #(
  parameter int BCLK_HALF_DIV = 2,
  parameter int SAMPLE_WIDTH  = 16,
  parameter int SLOT_BITS     = 32
) (
  input  logic                    master_clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic                    sample_clk_en,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sd,
  output logic                    busy
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] LR_LO    = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] LR_HI    = BIT_W'(FRAME_BITS - 2);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DIV_W-1:0]        r_div_cnt;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [SAMPLE_WIDTH-1:0] r_hold;
  logic                    r_bclk;
  logic                    r_lrclk;
  logic                    r_sd;
  logic                    r_strobe;

  logic [DIV_W-1:0]        w_div_nxt;
  logic [BIT_W-1:0]        w_bit_nxt;
  logic [SAMPLE_WIDTH-1:0] w_hold_nxt;
  logic                    w_bclk_nxt;
  logic                    w_lrclk_nxt;
  logic                    w_sd_nxt;
  logic                    w_strobe_nxt;

  logic                    w_tc;
  logic                    w_fall;
  logic [BIT_W-1:0]        w_nb;
  logic [BIT_W-1:0]        w_k;
  logic [SAMPLE_WIDTH-1:0] w_shifted;
  logic                    w_frame_start;

  assign w_tc          = (r_div_cnt == DIV_LAST);
  assign w_fall        = (r_state == S_RUN) && w_tc && r_bclk;
  assign w_nb          = (r_bit_cnt == BIT_LAST) ? '0 : (r_bit_cnt + BIT_ONE);
  assign w_k           = (w_nb >= SLOT_N) ? (w_nb - SLOT_N) : w_nb;
  // Shifting past the sample width yields the zero padding bits for free.
  assign w_shifted     = r_hold << w_k;
  assign w_frame_start = w_fall && (w_nb == '0);

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (w_frame_start && !enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_div_nxt    = r_div_cnt;
    w_bit_nxt    = r_bit_cnt;
    w_hold_nxt   = r_hold;
    w_bclk_nxt   = r_bclk;
    w_lrclk_nxt  = r_lrclk;
    w_sd_nxt     = r_sd;
    w_strobe_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_nxt   = '0;
        w_bit_nxt   = BIT_LAST;
        w_bclk_nxt  = 1'b0;
        w_lrclk_nxt = 1'b0;
        w_sd_nxt    = 1'b0;
      end
      S_RUN: begin
        w_div_nxt = w_tc ? '0 : (r_div_cnt + DIV_ONE);
        if (w_tc) w_bclk_nxt = ~r_bclk;
        if (w_fall) begin
          w_bit_nxt   = w_nb;
          w_lrclk_nxt = (w_nb >= LR_LO) && (w_nb <= LR_HI);
          w_sd_nxt    = w_shifted[SAMPLE_WIDTH-1];
          if (w_frame_start) begin
            // The MSB goes out this edge, so it must come from the fresh sample.
            if (enable) begin
              w_hold_nxt   = sample_in;
              w_sd_nxt     = sample_in[SAMPLE_WIDTH-1];
              w_strobe_nxt = 1'b1;
            end else begin
              w_sd_nxt    = 1'b0;
              w_lrclk_nxt = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_bit_cnt <= BIT_LAST;
      r_hold    <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_sd      <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_hold    <= w_hold_nxt;
      r_bclk    <= w_bclk_nxt;
      r_lrclk   <= w_lrclk_nxt;
      r_sd      <= w_sd_nxt;
      r_strobe  <= w_strobe_nxt;
    end
  end

  assign sample_clk_en = r_strobe;
  assign i2s_bclk      = r_bclk;
  assign i2s_lrclk     = r_lrclk;
  assign i2s_sd        = r_sd;
  assign busy          = (r_state == S_RUN);

endmodule

// File: tb/tb_i2s_frame_serializer.sv
// Bench for i2s_frame_serializer: two instances (half-divider 2 and 1) observed as an
// I2S receiver would see them, against per-frame expectations built from the I2S rules.
module tb_i2s_frame_serializer;

  logic        master_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en;
  logic [15:0] sin [2];
  logic [1:0]  strb, bclk, lr, sd, busy;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 master_clk = ~master_clk;
  always @(posedge master_clk) cyc <= cyc + 1;

  i2s_frame_serializer #(.BCLK_HALF_DIV(2), .SAMPLE_WIDTH(16), .SLOT_BITS(32)) u_div2 (
    .master_clk(master_clk), .rst(rst), .enable(en[0]), .sample_in(sin[0]),
    .sample_clk_en(strb[0]), .i2s_bclk(bclk[0]), .i2s_lrclk(lr[0]), .i2s_sd(sd[0]),
    .busy(busy[0]));

  i2s_frame_serializer #(.BCLK_HALF_DIV(1), .SAMPLE_WIDTH(16), .SLOT_BITS(32)) u_div1 (
    .master_clk(master_clk), .rst(rst), .enable(en[1]), .sample_in(sin[1]),
    .sample_clk_en(strb[1]), .i2s_bclk(bclk[1]), .i2s_lrclk(lr[1]), .i2s_sd(sd[1]),
    .busy(busy[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Frame bit p as a receiver sees it: slot bit k = p mod 32, MSB first, zero padded.
  function automatic logic [63:0] exp_sd(input logic [15:0] s);
    logic [63:0] v = '0;
    for (int p = 0; p < 64; p++) begin
      int k = p % 32;
      if (k < 16) v[p] = s[15-k];
    end
    return v;
  endfunction

  // Word select leads each slot by one bit: high from bit 31 through bit 62.
  function automatic logic [63:0] exp_lr();
    logic [63:0] v = '0;
    for (int p = 31; p <= 62; p++) v[p] = 1'b1;
    return v;
  endfunction

  task automatic wait_busy(input int u, output int t);
    t = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge master_clk);
      if (busy[u]) begin
        t = cyc;
        return;
      end
    end
    chk("busy_wait", 64'd0, 64'd1);
  endtask

  // Waits for the frame strobe, then samples SD/LRCLK on each BCLK rise for 64 bits.
  // sample_in is switched to nxt_s `dly` cycles after the strobe; optional enable drop
  // or reset at a given bit index.
  task automatic capture_frame(input int u, input int div, input logic [15:0] exp_s,
                               input logic [15:0] nxt_s, input int dly,
                               input int drop_at, input int rst_at, output int t_strobe);
    logic [63:0] g_sd = '0;
    logic [63:0] g_lr = '0;
    int nbits = 0, since = 0, t_r0 = 0, t_r1 = 0;
    logic prev;
    bit got = 0;
    t_strobe = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge master_clk);
      if (strb[u]) got = 1;
    end
    if (!got) begin
      chk("strobe_wait", 64'd0, 64'd1);
      return;
    end
    t_strobe = cyc;
    prev = bclk[u];
    while (nbits < 64 && since < 2000) begin
      @(negedge master_clk);
      since++;
      if (since == dly) sin[u] = nxt_s;
      if (bclk[u] && !prev) begin
        g_sd[nbits] = sd[u];
        g_lr[nbits] = lr[u];
        if (nbits == 0) t_r0 = cyc;
        if (nbits == 1) t_r1 = cyc;
        if (nbits == drop_at) en[u] = 1'b0;
        if (nbits == rst_at) begin
          rst = 1'b0;
          #1;
          chk("reset_outputs", 64'({strb[u], bclk[u], lr[u], sd[u], busy[u]}), 64'd0);
          return;
        end
        nbits++;
      end
      prev = bclk[u];
    end
    chk("bits_seen", 64'(nbits), 64'd64);
    chk("bclk_period", 64'(t_r1 - t_r0), 64'(2 * div));
    chk("sd_frame", g_sd, exp_sd(exp_s));
    chk("lr_frame", g_lr, exp_lr());
  endtask

  task automatic watch_idle(input int n);
    int n_strb = 0, n_rise = 0, n_busy = 0;
    logic [1:0] prev = bclk;
    for (int i = 0; i < n; i++) begin
      @(negedge master_clk);
      for (int u = 0; u < 2; u++) begin
        if (strb[u]) n_strb++;
        if (bclk[u] && !prev[u]) n_rise++;
        if (busy[u]) n_busy++;
      end
      prev = bclk;
    end
    chk("idle_strobes", 64'(n_strb), 64'd0);
    chk("idle_bclk_edges", 64'(n_rise), 64'd0);
    chk("idle_busy", 64'(n_busy), 64'd0);
  endtask

  // Start an instance and run fixed plus random frames, checking latency and period.
  task automatic run_stream(input int u, input int div, input int n_rand);
    int t_busy, t_s, t_prev;
    logic [15:0] cur, nxt;
    int dmax = 45 * div;
    @(negedge master_clk);
    sin[u] = 16'hA5C3;
    en[u]  = 1'b1;
    wait_busy(u, t_busy);
    capture_frame(u, div, 16'hA5C3, 16'hA5C3, 0, -1, -1, t_s);
    chk("first_strobe", 64'(t_s - t_busy), 64'(2 * div));
    t_prev = t_s;
    capture_frame(u, div, 16'hA5C3, 16'h1234, 3, -1, -1, t_s);
    chk("strobe_period", 64'(t_s - t_prev), 64'(128 * div));
    t_prev = t_s;
    capture_frame(u, div, 16'h1234, 16'h7FFF, 3, -1, -1, t_s);
    t_prev = t_s;
    capture_frame(u, div, 16'h7FFF, 16'h8000, 5, -1, -1, t_s);
    capture_frame(u, div, 16'h8000, 16'hFFFF, 7, -1, -1, t_s);
    cur = 16'hFFFF;
    for (int i = 0; i < n_rand; i++) begin
      nxt = 16'($urandom);
      t_prev = t_s;
      capture_frame(u, div, cur, nxt, int'($urandom_range(1, dmax)), -1, -1, t_s);
      chk("strobe_period", 64'(t_s - t_prev), 64'(128 * div));
      cur = nxt;
    end
    // Enable dropped mid-frame: frame still completes, then IDLE.
    capture_frame(u, div, cur, cur, 0, 20, -1, t_s);
    repeat (2 * div + 2) @(negedge master_clk);
    chk("after_drop_outputs", 64'({bclk[u], lr[u], sd[u], busy[u]}), 64'd0);
    watch_idle(300);
    @(negedge master_clk);
    sin[u] = 16'h0F0F;
    en[u]  = 1'b1;
    wait_busy(u, t_busy);
    capture_frame(u, div, 16'h0F0F, 16'h0F0F, 0, -1, -1, t_s);
    chk("restart_strobe", 64'(t_s - t_busy), 64'(2 * div));
  endtask

  initial begin
    int t_busy, t_s;
    en = 2'b00;
    sin[0] = 16'h0;
    sin[1] = 16'h0;
    #2 rst = 1'b0;
    repeat (3) @(negedge master_clk);
    chk("reset_state", 64'({strb, bclk, lr, sd, busy}), 64'd0);
    rst = 1'b1;

    run_stream(0, 2, 4);

    // Reset asserted at bit 40 of a running frame, released with enable low.
    capture_frame(0, 2, 16'h0F0F, 16'hA5C3, 3, -1, -1, t_s);
    capture_frame(0, 2, 16'hA5C3, 16'hA5C3, 0, -1, 40, t_s);
    en = 2'b00;
    @(negedge master_clk);
    rst = 1'b1;
    watch_idle(300);

    run_stream(1, 1, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
